// File: rtl/mem_access_unit.sv
// RV32I memory stage: load/store to byte-lane data bus with req/ready handshake.
// Optional MEM_PERF_COUNT_EN adds a 32-bit Stall_Count output.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_R_En_M,
  input  logic        MEM_W_En_M,
  input  logic [2:0]  Funct3_M,
  input  logic [31:0] ALU_Out_M,
  input  logic [31:0] Store_Data_M,
  output logic [31:0] MEM_Out_M,
  output logic        Stall_M,
  output logic        Misaligned_M,
  output logic        Bus_Err_M,
  output logic        DBUS_Req,
  output logic        DBUS_We,
  output logic [31:0] DBUS_Addr,
  output logic [3:0]  DBUS_Be,
  output logic [31:0] DBUS_WData,
  input  logic [31:0] DBUS_RData,
`ifdef MEM_PERF_COUNT_EN
  output logic [31:0] Stall_Count,
`endif
  input  logic        DBUS_Ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        aligned;
  logic        go;
  logic [1:0]  a_lo;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign access  = MEM_R_En_M | MEM_W_En_M;
  assign a_lo    = ALU_Out_M[1:0];
  assign is_byte = (Funct3_M[1:0] == 2'b00);
  assign is_half = (Funct3_M[1:0] == 2'b01);
  assign is_word = Funct3_M[1];

  assign aligned = is_byte
                 | (is_half & ~a_lo[0])
                 | (is_word & (a_lo == 2'b00));

  assign go           = access & aligned;
  assign Misaligned_M = access & ~aligned;

  assign Stall_M = RST & ((state == S_WAIT)
                 | ((state == S_IDLE) & go));

  always_comb begin
    be_w    = 4'b1111;
    wdata_w = Store_Data_M;
    unique case (1'b1)
      is_byte: begin
        be_w    = 4'b0001 << a_lo;
        wdata_w = {4{Store_Data_M[7:0]}};
      end
      is_half: begin
        be_w    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_w = {2{Store_Data_M[15:0]}};
      end
      is_word: begin
        be_w    = 4'b1111;
        wdata_w = Store_Data_M;
      end
    endcase
  end

  always_comb begin
    ld_b   = DBUS_RData[{a_lo, 3'b000} +: 8];
    ld_h   = a_lo[1] ? DBUS_RData[31:16] : DBUS_RData[15:0];
    ld_ext = DBUS_RData;
    unique case (1'b1)
      is_byte: ld_ext = {{24{ld_b[7] & ~Funct3_M[2]}}, ld_b};
      is_half: ld_ext = {{16{ld_h[15] & ~Funct3_M[2]}}, ld_h};
      is_word: ld_ext = DBUS_RData;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      DBUS_Req   <= 1'b0;
      DBUS_We    <= 1'b0;
      DBUS_Addr  <= '0;
      DBUS_Be    <= '0;
      DBUS_WData <= '0;
      MEM_Out_M  <= '0;
      Bus_Err_M  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            DBUS_Req   <= 1'b1;
            DBUS_We    <= MEM_W_En_M;
            DBUS_Addr  <= {ALU_Out_M[31:2], 2'b00};
            DBUS_Be    <= MEM_W_En_M ? be_w : 4'b1111;
            DBUS_WData <= MEM_W_En_M ? wdata_w : 32'h0;
            cnt        <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (DBUS_Ready) begin
            MEM_Out_M <= MEM_W_En_M ? 32'h0 : ld_ext;
            DBUS_Req  <= 1'b0;
            DBUS_We   <= 1'b0;
            state     <= S_DONE;
          end else if (cnt == 8'(MAX_WAIT - 1)) begin
            MEM_Out_M <= '0;
            Bus_Err_M <= 1'b1;
            DBUS_Req  <= 1'b0;
            DBUS_We   <= 1'b0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: begin
          MEM_Out_M <= '0;
          Bus_Err_M <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_PERF_COUNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      Stall_Count <= '0;
    else if (Stall_M)
      Stall_Count <= Stall_Count + 32'd1;
  end
`endif

endmodule
